// File: rtl/ssm_pkg.sv
//==============================================================================
// Module      : ssm_pkg
// Description : Shared types and sizes for the SSM tile feeder: lane/scalar
//               widths, tile vector type, feeder state encoding and the
//               derived tile count / counter widths.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ssm_pkg;

    localparam int DW       = 16;                 // scalar / lane width (fp16)
    localparam int N_TILE   = 16;                 // lanes per tile
    localparam int N_STATE  = 128;                // state length per frame
    localparam int AW       = 8;                  // tile memory address width

    localparam int TILE_W   = N_TILE * DW;        // bits per tile vector
    localparam int NT       = N_STATE / N_TILE;   // tiles per frame
    localparam int RD_CNT_W = $clog2(NT + 1);     // holds 0..NT inclusive
    localparam int FIFO_W   = 3 * TILE_W + 1;     // {last, B, C, hprev}

    typedef logic [TILE_W-1:0] tile_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WAIT_Y = 2'd2
    } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/ssm_tile_feeder_if.sv
//==============================================================================
// Module      : ssm_tile_feeder_if
// Description : Bundle of host command, tile memory, tile stream and result
//               signals of the SSM tile feeder. master = feeder side,
//               slave = surrounding logic (host, memory, SSM block).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ssm_tile_feeder_if;
    import ssm_pkg::*;

    // host command / status
    logic            start_i;
    logic [AW-1:0]   base_i;
    logic [DW-1:0]   dt_i;
    logic [DW-1:0]   dA_i;
    logic [DW-1:0]   x_i;
    logic [DW-1:0]   D_i;
    logic            busy_o;
    logic            done_o;
    logic [DW-1:0]   y_o;
    logic            err_timeout_o;

    // tile memory read port
    logic            mem_rd_en_o;
    logic [AW-1:0]   mem_rd_addr_o;
    tile_vec_t       mem_B_i;
    tile_vec_t       mem_C_i;
    tile_vec_t       mem_h_i;

    // tile stream towards the SSM block
    logic            tile_valid_o;
    logic            tile_last_o;
    logic            tile_ready_i;
    logic [DW-1:0]   dt_o;
    logic [DW-1:0]   dA_o;
    logic [DW-1:0]   x_o;
    logic [DW-1:0]   D_o;
    tile_vec_t       B_tile_o;
    tile_vec_t       C_tile_o;
    tile_vec_t       hprev_tile_o;

    // result from the SSM block
    logic [DW-1:0]   y_final_i;
    logic            y_final_valid_i;

    modport master (
        input  start_i, base_i, dt_i, dA_i, x_i, D_i,
        output busy_o, done_o, y_o, err_timeout_o,
        output mem_rd_en_o, mem_rd_addr_o,
        input  mem_B_i, mem_C_i, mem_h_i,
        output tile_valid_o, tile_last_o,
        input  tile_ready_i,
        output dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o, hprev_tile_o,
        input  y_final_i, y_final_valid_i
    );

    modport slave (
        output start_i, base_i, dt_i, dA_i, x_i, D_i,
        input  busy_o, done_o, y_o, err_timeout_o,
        input  mem_rd_en_o, mem_rd_addr_o,
        output mem_B_i, mem_C_i, mem_h_i,
        input  tile_valid_o, tile_last_o,
        output tile_ready_i,
        input  dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o, hprev_tile_o,
        output y_final_i, y_final_valid_i
    );

endinterface

`default_nettype wire

// File: rtl/ssm_tile_fifo2.sv
//==============================================================================
// Module      : ssm_tile_fifo2
// Description : Two-entry FIFO with occupancy count, head visible on rd_data.
//               Writes are unconditional; the writer guarantees space.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssm_tile_fifo2
    import ssm_pkg::*;
#(
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    // A pop on an empty FIFO is dropped so the count can never underflow
    always_comb begin
        w_pop = rd_en && (r_count != 2'd0);
    end

    // Storage, pointers and occupancy; reset empties and zeroes the entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({wr_en, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/ssm_tile_feeder.sv
//==============================================================================
// Module      : ssm_tile_feeder
// Description : Frame sequencer for the SSM block. Captures frame scalars on
//               start, reads NT tile triples from tile memory under a credit
//               rule, streams them with valid/last/ready through a 2-entry
//               FIFO, then waits for y_final and returns it with done_o.
//               Optional macro SSM_FEEDER_TIMEOUT_EN adds a WAIT_Y watchdog
//               of Y_TIMEOUT cycles that ends the frame with err_timeout_o.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssm_tile_feeder
    import ssm_pkg::*;
#(
    parameter int Y_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    ssm_tile_feeder_if.master   bus
);

    localparam logic [RD_CNT_W-1:0] c_nt      = RD_CNT_W'(NT);
    localparam logic [RD_CNT_W-1:0] c_nt_last = RD_CNT_W'(NT - 1);

    feeder_state_t       r_state;
    logic [AW-1:0]       r_base;
    logic [DW-1:0]       r_dt;
    logic [DW-1:0]       r_dA;
    logic [DW-1:0]       r_x;
    logic [DW-1:0]       r_D;
    logic [DW-1:0]       r_y;
    logic                r_busy;
    logic                r_done;
    logic [RD_CNT_W-1:0] r_rd_cnt;
    logic                r_rd_vld;   // read data is on mem_*_i this cycle
    logic                r_rd_last;  // ...and it is the frame's final tile

    logic [1:0]          w_fifo_count;
    logic [FIFO_W-1:0]   w_fifo_head;
    logic [FIFO_W-1:0]   w_fifo_wdata;
    logic                w_tile_valid;
    logic                w_head_last;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_credit_ok;
    logic                w_rd_en;

`ifdef SSM_FEEDER_TIMEOUT_EN
    localparam int               WAIT_W      = $clog2(Y_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(Y_TIMEOUT - 1);
    logic [WAIT_W-1:0]           r_wait_cnt;
    logic                        r_err;
`else
    logic                        w_unused_timeout;
    assign w_unused_timeout = (Y_TIMEOUT != 0);
`endif

    // Issue/credit: a new read lands two edges later, so occupancy plus the
    // read already returning, minus this cycle's pop, must leave a free slot
    always_comb begin
        w_tile_valid = (w_fifo_count != 2'd0);
        w_head_last  = w_fifo_head[FIFO_W-1];
        w_pop        = w_tile_valid && bus.tile_ready_i;
        w_occ        = {1'b0, w_fifo_count} + {2'b00, r_rd_vld};
        w_credit_ok  = (w_occ <= (3'd1 + {2'b00, w_pop}));
        w_rd_en      = (r_state == ST_FETCH) && (r_rd_cnt < c_nt) && w_credit_ok;
        w_fifo_wdata = {r_rd_last, bus.mem_B_i, bus.mem_C_i, bus.mem_h_i};
    end

    // Track which cycle carries returning read data; reset drops it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= w_rd_en;
            r_rd_last <= w_rd_en && (r_rd_cnt == c_nt_last);
        end
    end

    // Frame sequencer: IDLE -> FETCH -> WAIT_Y -> IDLE with registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_dt     <= '0;
            r_dA     <= '0;
            r_x      <= '0;
            r_D      <= '0;
            r_y      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_cnt <= '0;
`ifdef SSM_FEEDER_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SSM_FEEDER_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_base   <= bus.base_i;
                        r_dt     <= bus.dt_i;
                        r_dA     <= bus.dA_i;
                        r_x      <= bus.x_i;
                        r_D      <= bus.D_i;
                        r_busy   <= 1'b1;
                        r_rd_cnt <= '0;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                    if (w_pop && w_head_last) begin
                        r_state <= ST_WAIT_Y;
`ifdef SSM_FEEDER_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                ST_WAIT_Y: begin
                    if (bus.y_final_valid_i) begin
                        r_y     <= bus.y_final_i;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`ifdef SSM_FEEDER_TIMEOUT_EN
                    else if (r_wait_cnt == c_wait_last) begin
                        r_y     <= '0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ssm_tile_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_rd_vld),
        .wr_data (w_fifo_wdata),
        .rd_en   (w_pop),
        .rd_data (w_fifo_head),
        .count   (w_fifo_count)
    );

    // Returning read data must always find a free slot
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_rd_vld && (w_fifo_count == 2'd2) && !w_pop));

    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.y_o           = r_y;
`ifdef SSM_FEEDER_TIMEOUT_EN
    assign bus.err_timeout_o = r_err;
`else
    assign bus.err_timeout_o = 1'b0;
`endif
    assign bus.mem_rd_en_o   = w_rd_en;
    assign bus.mem_rd_addr_o = w_rd_en ? (r_base + AW'(r_rd_cnt)) : '0;
    assign bus.tile_valid_o  = w_tile_valid;
    assign bus.tile_last_o   = w_tile_valid && w_head_last;
    assign bus.B_tile_o      = w_fifo_head[3*TILE_W-1 -: TILE_W];
    assign bus.C_tile_o      = w_fifo_head[2*TILE_W-1 -: TILE_W];
    assign bus.hprev_tile_o  = w_fifo_head[TILE_W-1:0];
    assign bus.dt_o          = r_dt;
    assign bus.dA_o          = r_dA;
    assign bus.x_o           = r_x;
    assign bus.D_o           = r_D;

endmodule

`default_nettype wire

// File: tb/tb_ssm_tile_feeder.sv
//==============================================================================
// Module      : tb_ssm_tile_feeder
// Description : Self-checking bench for ssm_tile_feeder. Frames come from a
//               table plus random entries; a memory model answers reads and
//               a scoreboard derives addresses, payloads, last and timing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ssm_tile_feeder;
    import ssm_pkg::*;

    localparam int Y_TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssm_tile_feeder_if bus ();

    ssm_tile_feeder #(.Y_TIMEOUT(Y_TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] base;
        int            mode;   // 0: ready=1, 1: 1,0,0,1,0,1 pattern, 2: random
        logic [DW-1:0] y;
        int            gap;    // cycles between last tile and y_final_valid
        bit            mid;    // pulse start_i during the frame
        bit            early;  // pulse y_final_valid_i during FETCH
    } frame_t;

    int            n_vec = 0;
    int            n_bad = 0;
    tile_vec_t     mem_b [256];
    tile_vec_t     mem_c [256];
    tile_vec_t     mem_h [256];

    logic [AW-1:0] f_base;
    int            f_mode;
    int            cyc, n_rd, n_pop;
    bit            pend;
    logic [AW-1:0] pend_addr;
    bit            prev_stall;
    tile_vec_t     prev_b, prev_c, prev_h;
    logic [4*DW-1:0] cap_sc;

    task automatic chk(input string name, input logic [TILE_W-1:0] act,
                       input logic [TILE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tile_vec_t rnd_tile();
        tile_vec_t v;
        for (int i = 0; i < TILE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Read data for the previous cycle's read; garbage otherwise
    task automatic drive_mem();
        if (pend) begin
            bus.mem_B_i = mem_b[pend_addr];
            bus.mem_C_i = mem_c[pend_addr];
            bus.mem_h_i = mem_h[pend_addr];
        end else begin
            bus.mem_B_i = rnd_tile();
            bus.mem_C_i = rnd_tile();
            bus.mem_h_i = rnd_tile();
        end
        pend = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {bus.busy_o, bus.done_o, bus.err_timeout_o,
                            bus.mem_rd_en_o, bus.tile_valid_o, bus.tile_last_o}, '0);
        chk({tag, "_addr_y"}, {bus.mem_rd_addr_o, bus.y_o}, '0);
        chk({tag, "_scalars"}, {bus.dt_o, bus.dA_o, bus.x_o, bus.D_o}, '0);
        chk({tag, "_B"}, bus.B_tile_o, '0);
        chk({tag, "_C"}, bus.C_tile_o, '0);
        chk({tag, "_h"}, bus.hprev_tile_o, '0);
    endtask

    task automatic start_frame(input frame_t f);
        @(negedge clk);
        drive_mem();
        bus.start_i = 1'b1;
        bus.base_i  = f.base;
        bus.dt_i = DW'($urandom); bus.dA_i = DW'($urandom);
        bus.x_i  = DW'($urandom); bus.D_i  = DW'($urandom);
        cap_sc = {bus.dt_i, bus.dA_i, bus.x_i, bus.D_i};
        bus.y_final_valid_i = 1'b0;
        f_base = f.base; f_mode = f.mode;
        cyc = 0; n_rd = 0; n_pop = 0; prev_stall = 0;
    endtask

    // One FETCH-phase cycle: drive, then check against the frame model
    task automatic fetch_cycle(input bit mid, input bit early);
        logic [AW-1:0] ea;
        int k;
        @(negedge clk);
        drive_mem();
        cyc++;
        k = cyc % 6;
        case (f_mode)
            0:       bus.tile_ready_i = 1'b1;
            1:       bus.tile_ready_i = (k == 0 || k == 3 || k == 5);
            default: bus.tile_ready_i = 1'($urandom_range(0, 1));
        endcase
        bus.start_i = mid && (cyc == 4);
        if (bus.start_i) begin
            bus.base_i = f_base ^ 8'h55;
            bus.dt_i = ~bus.dt_i; bus.x_i = ~bus.x_i;
        end
        bus.y_final_valid_i = early && (cyc == 5);
        bus.y_final_i = 16'h1234;
        #1;
        chk("busy_in_fetch", bus.busy_o, 1'b1);
        chk("no_done_in_fetch", bus.done_o, 1'b0);
        chk("scalars_hold", {bus.dt_o, bus.dA_o, bus.x_o, bus.D_o}, cap_sc);
        chk("fifo_count_le2", dut.w_fifo_count <= 2'd2, 1'b1);
        if (f_mode == 0) begin
            chk("rd_en_timing", bus.mem_rd_en_o, (cyc >= 1 && cyc <= NT));
            chk("valid_timing", bus.tile_valid_o, (cyc >= 3 && cyc <= NT + 2));
        end
        if (bus.mem_rd_en_o) begin
            ea = f_base + AW'(n_rd);
            chk("rd_addr", bus.mem_rd_addr_o, ea);
            pend = 1'b1;
            pend_addr = bus.mem_rd_addr_o;
            n_rd++;
            chk("rd_count_le_nt", n_rd <= NT, 1'b1);
        end
        if (prev_stall) begin
            chk("stall_valid", bus.tile_valid_o, 1'b1);
            chk("stall_B", bus.B_tile_o, prev_b);
            chk("stall_C", bus.C_tile_o, prev_c);
            chk("stall_h", bus.hprev_tile_o, prev_h);
            chk("stall_last", bus.tile_last_o, (n_pop == NT - 1));
        end
        if (bus.tile_valid_o && bus.tile_ready_i) begin
            ea = f_base + AW'(n_pop);
            chk("tile_B", bus.B_tile_o, mem_b[ea]);
            chk("tile_C", bus.C_tile_o, mem_c[ea]);
            chk("tile_h", bus.hprev_tile_o, mem_h[ea]);
            chk("tile_last", bus.tile_last_o, (n_pop == NT - 1));
            n_pop++;
        end
        prev_stall = bus.tile_valid_o && !bus.tile_ready_i;
        prev_b = bus.B_tile_o; prev_c = bus.C_tile_o; prev_h = bus.hprev_tile_o;
    endtask

    task automatic stream_tiles(input bit mid, input bit early);
        int guard = 0;
        while (n_pop < NT && guard < 300) begin
            fetch_cycle(mid, early);
            guard++;
        end
        chk("frame_complete", n_pop, NT);
        chk("reads_issued", n_rd, NT);
    endtask

    // WAIT_Y with y returned after gap cycles
    task automatic finish_y(input logic [DW-1:0] yv, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); drive_mem();
            bus.tile_ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("wait_busy", bus.busy_o, 1'b1);
            chk("wait_no_done", bus.done_o, 1'b0);
            chk("wait_no_valid", bus.tile_valid_o, 1'b0);
        end
        @(negedge clk); drive_mem();
        bus.y_final_valid_i = 1'b1; bus.y_final_i = yv;
        #1;
        chk("done_not_early", bus.done_o, 1'b0);
        @(negedge clk); drive_mem();
        bus.y_final_valid_i = 1'b0; bus.y_final_i = ~yv;
        #1;
        chk("done_pulse", bus.done_o, 1'b1);
        chk("y_out", bus.y_o, yv);
        chk("busy_fall", bus.busy_o, 1'b0);
        chk("no_err", bus.err_timeout_o, 1'b0);
        @(negedge clk); drive_mem();
        #1;
        chk("done_one_cycle", bus.done_o, 1'b0);
        chk("y_held", bus.y_o, yv);
    endtask

    frame_t tbl [6];
    frame_t fr;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_b[i] = rnd_tile(); mem_c[i] = rnd_tile(); mem_h[i] = rnd_tile();
        end
        tbl[0] = '{8'h10, 0, 16'h3C00, 5, 1'b0, 1'b0};
        tbl[1] = '{8'hFA, 0, 16'hBEEF, 0, 1'b1, 1'b1};
        tbl[2] = '{8'h40, 1, 16'h0001, 2, 1'b0, 1'b0};
        tbl[3] = '{8'hFE, 1, 16'h7BFF, 1, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 2, 16'hC000, 3, 1'b0, 1'b1};
        tbl[5] = '{8'hFC, 2, 16'h5555, 0, 1'b0, 1'b0};

        pend = 1'b0;
        bus.start_i = 1'b0; bus.base_i = '0;
        bus.dt_i = '0; bus.dA_i = '0; bus.x_i = '0; bus.D_i = '0;
        bus.mem_B_i = '0; bus.mem_C_i = '0; bus.mem_h_i = '0;
        bus.tile_ready_i = 1'b0; bus.y_final_i = '0; bus.y_final_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            start_frame(tbl[i]);
            stream_tiles(tbl[i].mid, tbl[i].early);
            finish_y(tbl[i].y, tbl[i].gap);
        end

        // random frames
        for (int i = 0; i < 6; i++) begin
            fr.base = AW'($urandom); fr.mode = $urandom_range(0, 2);
            fr.y = DW'($urandom_range(1, 65535)); fr.gap = $urandom_range(0, 6);
            fr.mid = 1'($urandom_range(0, 1)); fr.early = 1'($urandom_range(0, 1));
            start_frame(fr);
            stream_tiles(fr.mid, fr.early);
            finish_y(fr.y, fr.gap);
        end

        // no y returned
        fr = '{8'h33, 0, 16'h0, 0, 1'b0, 1'b0};
        start_frame(fr);
        stream_tiles(1'b0, 1'b0);
`ifdef SSM_FEEDER_TIMEOUT_EN
        for (int g = 1; g <= Y_TMO + 1; g++) begin
            @(negedge clk); drive_mem(); #1;
            if (g <= Y_TMO) begin
                chk("tmo_no_done", bus.done_o, 1'b0);
                chk("tmo_busy", bus.busy_o, 1'b1);
            end else begin
                chk("tmo_done", bus.done_o, 1'b1);
                chk("tmo_err", bus.err_timeout_o, 1'b1);
                chk("tmo_y_zero", bus.y_o, '0);
                chk("tmo_busy_fall", bus.busy_o, 1'b0);
            end
        end
        @(negedge clk); drive_mem(); #1;
        chk("tmo_err_one_cycle", bus.err_timeout_o, 1'b0);
`else
        for (int g = 0; g < 40; g++) begin
            @(negedge clk); drive_mem(); #1;
            chk("notmo_busy", bus.busy_o, 1'b1);
            chk("notmo_no_done", {bus.done_o, bus.err_timeout_o}, 2'b00);
        end
        finish_y(16'h2468, 0);
`endif

        // reset mid-frame after three tiles, then a clean replay
        fr = '{8'h20, 0, 16'h1357, 2, 1'b0, 1'b0};
        start_frame(fr);
        while (n_pop < 3 && cyc < 50) fetch_cycle(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(negedge clk);
        pend = 1'b0;
        rst = 1'b0;
        start_frame(fr);
        stream_tiles(1'b0, 1'b0);
        finish_y(fr.y, fr.gap);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
